// File: rtl/broadcast_medium_pkg.sv
// Shared types and default sizing for the broadcast medium scheduler.
package broadcast_medium_pkg;

    localparam int BM_N_NODES  = 4;
    localparam int BM_N_PHASES = 4;
    localparam int BM_LEN_W    = 16;
    localparam int BM_DELAY    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row i, column j: node i hears node j.
    typedef logic [BM_N_NODES-1:0][BM_N_NODES-1:0] adj_t;

    typedef struct packed {
        adj_t                adj;
        logic [BM_LEN_W-1:0] len;
    } phase_entry_t;

endpackage

// File: rtl/medium_delay_line.sv
// N-bit shift register of DEPTH stages; DEPTH == 0 is a plain wire.
module medium_delay_line #(
    parameter int W     = 4,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are not needed when the line has no stages.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            // Shift the transmit vector one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage[k] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/broadcast_medium_scheduler.sv
// Shared-medium model: per-phase adjacency table, phase sequencer and the
// registered OR / collision combine of the delayed transmit vector.
module broadcast_medium_scheduler
    import broadcast_medium_pkg::*;
#(
    parameter int N_NODES  = BM_N_NODES,
    parameter int N_PHASES = BM_N_PHASES,
    parameter int LEN_W    = BM_LEN_W,
    parameter int DELAY    = BM_DELAY,
    localparam int PW      = $clog2(N_PHASES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [PW-1:0]                cfg_phase,
    input  logic [N_NODES*N_NODES-1:0]   cfg_adj,
    input  logic [LEN_W-1:0]             cfg_len,
    output logic                         cfg_err,
    input  logic                         start,
    input  logic                         loop_en,
    input  logic                         abort,
    input  logic [N_NODES-1:0]           tx,
    output logic [N_NODES-1:0]           rx,
    output logic [N_NODES-1:0]           collision,
    output logic [PW-1:0]                phase_idx,
    output logic                         running,
    output logic                         done
);

    localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
    localparam logic [N_NODES-1:0] NODE_ONE   = N_NODES'(1);
    localparam logic [PW-1:0]      LAST_PHASE = PW'(N_PHASES - 1);

    state_e                       state_reg;
    logic [LEN_W-1:0]             cnt_reg;
    logic                         loop_reg;
    logic [N_NODES*N_NODES-1:0]   adj_tbl [N_PHASES];
    logic [LEN_W-1:0]             len_tbl [N_PHASES];

    logic [N_NODES-1:0]           tx_d;
    logic [N_NODES*N_NODES-1:0]   cur_adj;
    logic [LEN_W-1:0]             cur_len;
    logic                         phase_end;
    logic [N_NODES-1:0]           rx_next;
    logic [N_NODES-1:0]           collision_next;

    medium_delay_line #(
        .W     (N_NODES),
        .DEPTH (DELAY - 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tx),
        .dout  (tx_d)
    );

    assign cur_adj   = adj_tbl[phase_idx];
    // A zero-length phase still occupies one cycle.
    assign cur_len   = (len_tbl[phase_idx] == '0) ? LEN_ONE : len_tbl[phase_idx];
    assign phase_end = (cnt_reg == cur_len - LEN_ONE);

    // Per-node OR of enabled sources; two or more enabled sources is a collision.
    genvar gi;
    generate
        for (gi = 0; gi < N_NODES; gi++) begin : g_node
            logic [N_NODES-1:0] hits;
            assign hits               = cur_adj[gi*N_NODES +: N_NODES] & tx_d;
            assign rx_next[gi]        = |hits;
            assign collision_next[gi] = |(hits & (hits - NODE_ONE));
        end
    endgenerate

    assign running = (state_reg == RUN);
    assign done    = (state_reg == DONE);

    // Schedule table: writable only outside RUN; a write in RUN flags cfg_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            for (int k = 0; k < N_PHASES; k++) begin
                adj_tbl[k] <= '0;
                len_tbl[k] <= LEN_ONE;
            end
        end else begin
            cfg_err <= cfg_we && (state_reg == RUN);
            if (cfg_we && (state_reg != RUN)) begin
                adj_tbl[cfg_phase] <= cfg_adj;
                len_tbl[cfg_phase] <= cfg_len;
            end
        end
    end

    // Phase sequencer: abort wins over everything, start is ignored in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            phase_idx <= '0;
            loop_reg  <= 1'b0;
        end else if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            phase_idx <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (phase_end) begin
                        cnt_reg <= '0;
                        if (phase_idx != LAST_PHASE) begin
                            phase_idx <= phase_idx + 1'b1;
                        end else if (loop_reg) begin
                            phase_idx <= '0;
                        end else begin
                            state_reg <= DONE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + LEN_ONE;
                    end
                end
                default: begin
                    if (start) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        phase_idx <= '0;
                        loop_reg  <= loop_en;
                    end
                end
            endcase
        end
    end

    // Registered medium outputs, silenced outside RUN and on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx        <= '0;
            collision <= '0;
        end else if (abort || (state_reg != RUN)) begin
            rx        <= '0;
            collision <= '0;
        end else begin
            rx        <= rx_next;
            collision <= collision_next;
        end
    end

endmodule

// File: tb/tb_broadcast_medium_scheduler.sv
// Directed bench for broadcast_medium_scheduler (default 4 nodes, 4 phases, DELAY 1).
module tb_broadcast_medium_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_phase;
    logic [15:0] cfg_adj;
    logic [15:0] cfg_len;
    logic        cfg_err;
    logic        start;
    logic        loop_en;
    logic        abort;
    logic [3:0]  tx;
    logic [3:0]  rx;
    logic [3:0]  collision;
    logic [1:0]  phase_idx;
    logic        running;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] tx;
        logic [3:0] rx;
        logic [3:0] col;
    } vec_t;

    vec_t vecs [8];
    int   exp_ph [10];

    broadcast_medium_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_phase (cfg_phase),
        .cfg_adj   (cfg_adj),
        .cfg_len   (cfg_len),
        .cfg_err   (cfg_err),
        .start     (start),
        .loop_en   (loop_en),
        .abort     (abort),
        .tx        (tx),
        .rx        (rx),
        .collision (collision),
        .phase_idx (phase_idx),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("check %s value=%0h ok", name, act);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ph, input logic [15:0] adj, input logic [15:0] len);
        cfg_we    = 1'b1;
        cfg_phase = ph;
        cfg_adj   = adj;
        cfg_len   = len;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        // Adjacency 16'h8F16: row0={1,2}, row1={0}, row2=all, row3={3}.
        vecs[0] = '{tx: 4'b0000, rx: 4'b0000, col: 4'b0000};
        vecs[1] = '{tx: 4'b0001, rx: 4'b0110, col: 4'b0000};
        vecs[2] = '{tx: 4'b0011, rx: 4'b0111, col: 4'b0100};
        vecs[3] = '{tx: 4'b0110, rx: 4'b0101, col: 4'b0101};
        vecs[4] = '{tx: 4'b1000, rx: 4'b1100, col: 4'b0000};
        vecs[5] = '{tx: 4'b1111, rx: 4'b1111, col: 4'b0101};
        vecs[6] = '{tx: 4'b1001, rx: 4'b1110, col: 4'b0100};
        vecs[7] = '{tx: 4'b0100, rx: 4'b0101, col: 4'b0000};
        exp_ph = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 3};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_phase = '0; cfg_adj = '0; cfg_len = '0;
        start = 1'b0; loop_en = 1'b0; abort = 1'b0; tx = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx", rx, 4'h0);
        check("rst_col", collision, 4'h0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_phase", phase_idx, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write + start in the same cycle: full mesh, len 10
        cfg_we = 1'b1; cfg_phase = 2'd0; cfg_adj = 16'hFFFF; cfg_len = 16'd10;
        start = 1'b1; loop_en = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        check("start_running", running, 1'b1);
        check("start_phase", phase_idx, 2'd0);
        tx = 4'b0001;
        @(negedge clk);
        check("mesh_rx_new_adj", rx, 4'hF);
        check("mesh_col", collision, 4'h0);
        tx = 4'b0011;
        @(negedge clk);
        check("mesh_col_two_src", collision, 4'hF);
        check("mesh_rx_two_src", rx, 4'hF);

        // Config write while running is rejected
        cfg_we = 1'b1; cfg_adj = 16'h0000; cfg_len = 16'd1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("guard_cfg_err", cfg_err, 1'b1);
        check("guard_rx", rx, 4'hF);
        @(negedge clk);
        check("guard_cfg_err_clr", cfg_err, 1'b0);
        check("guard_rx_kept", rx, 4'hF);
        check("guard_col_kept", collision, 4'hF);

        // Abort from RUN
        do_abort();
        check("abort_running", running, 1'b0);
        check("abort_rx", rx, 4'h0);
        check("abort_col", collision, 4'h0);

        // Reset in the middle of a run
        tx = 4'hF; start = 1'b1; loop_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rerun_running", running, 1'b1);
        @(negedge clk);
        check("rerun_rx", rx, 4'hF);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rx", rx, 4'h0);
        check("midrst_col", collision, 4'h0);
        check("midrst_running", running, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_phase", phase_idx, 2'd0);
        check("midrst_cfg_err", cfg_err, 1'b0);
        rst_n = 1'b1; start = 1'b1; loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("iso_running", running, 1'b1);
        @(negedge clk);
        check("iso_rx", rx, 4'h0);
        check("iso_col", collision, 4'h0);
        @(negedge clk);
        check("iso_rx_2", rx, 4'h0);
        do_abort();

        // Table-driven combine vectors on a mixed topology
        tx = '0;
        cfg_write(2'd0, 16'h8F16, 16'd1000);
        start = 1'b1; loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx = vecs[i].tx;
            @(negedge clk);
            check($sformatf("vec%0d_rx", i), rx, vecs[i].rx);
            check($sformatf("vec%0d_col", i), collision, vecs[i].col);
        end
        do_abort();

        // Phase progression, lens {3,5,1,0}, no loop
        cfg_write(2'd0, 16'hFFFF, 16'd3);
        cfg_write(2'd1, 16'hFFFF, 16'd5);
        cfg_write(2'd2, 16'hFFFF, 16'd1);
        cfg_write(2'd3, 16'hFFFF, 16'd0);
        tx = 4'hF; start = 1'b1; loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("seq_phase_c%0d", k), phase_idx, exp_ph[k]);
            check($sformatf("seq_running_c%0d", k), running, 1'b1);
            @(negedge clk);
        end
        check("seq_done", done, 1'b1);
        check("seq_running_end", running, 1'b0);
        @(negedge clk);
        check("seq_done_hold", done, 1'b1);
        check("seq_rx_quiet", rx, 4'h0);
        check("seq_col_quiet", collision, 4'h0);

        // Same schedule with looping, started from DONE
        start = 1'b1; loop_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("loop_phase_c%0d", k), phase_idx, exp_ph[k]);
            check($sformatf("loop_done_c%0d", k), done, 1'b0);
            @(negedge clk);
        end
        check("loop_wrap_phase", phase_idx, 2'd0);
        check("loop_wrap_running", running, 1'b1);
        check("loop_wrap_done", done, 1'b0);
        check("loop_rx", rx, 4'hF);
        do_abort();
        check("loop_abort_running", running, 1'b0);
        check("loop_abort_done", done, 1'b0);
        check("loop_abort_rx", rx, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
